covert_tx_modulator: RTL and testbench

//  Transmit end of the environment-mediated covert channel. Host loads a message over UART.

---
 rtl/covert_tx_modulator.sv | 156 +++++++++++++++
 tb/tb_covert_tx_modulator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/covert_tx_modulator.sv
// Transmit side of the heater-based covert channel: a host frame (length + payload) is
// on/off keyed onto the heater bank one bit per BIT_PERIOD, then acknowledged over UART.
module covert_tx_modulator #(
  parameter int unsigned BIT_PERIOD  = 10_000_000,
  parameter int unsigned NUM_HEATERS = 64,
  parameter int unsigned MSG_DEPTH   = 16,
  parameter logic [7:0]  PREAMBLE    = 8'hAA,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  input  logic                   tx_busy,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic [NUM_HEATERS-1:0] heater_en,
  output logic                   busy,
  output logic                   end_led
);

  localparam int PW = $clog2(BIT_PERIOD);
  localparam int AW = $clog2(MSG_DEPTH) + 1;
  localparam int IW = $clog2(MSG_DEPTH);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PRE, DATA, GAP, ACK, DONE} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   period_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic            heater_bit_reg;
  logic [AW-1:0]   len_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [7:0]      rd_data_reg;
  logic [7:0]      msg_mem [MSG_DEPTH];

  logic len_ok, bit_wrap, byte_end, load_done, wr_en;

  always_comb begin
    len_ok    = (rx_data != 8'd0) && (32'(rx_data) <= MSG_DEPTH);
    bit_wrap  = (period_reg == PERIOD_LAST);
    byte_end  = bit_wrap && (bit_idx_reg == 3'd0);
    load_done = (wr_ptr_reg == len_reg);
    wr_en     = (state_reg == LOAD) && !load_done && rx_ready;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (rx_ready && len_ok) state_next = LOAD;
      LOAD: if (load_done) state_next = PRE;
      PRE:  if (byte_end) state_next = DATA;
      DATA: if (byte_end && (rd_ptr_reg == len_reg)) state_next = GAP;
      GAP:  if (bit_wrap) state_next = ACK;
      ACK:  if (!tx_busy) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Message buffer: plain array with registered read so it maps onto block RAM.
  // rd_ptr runs one byte ahead of the byte being shifted, so the read latency is hidden.
  always_ff @(posedge clk) begin
    if (wr_en) msg_mem[wr_ptr_reg[IW-1:0]] <= rx_data;
    rd_data_reg <= msg_mem[rd_ptr_reg[IW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_reg     <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      heater_bit_reg <= 1'b0;
      len_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      tx_data        <= '0;
      tx_start       <= 1'b0;
      busy           <= 1'b0;
      end_led        <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (state_next == LOAD) begin
            len_reg    <= AW'(rx_data);
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            end_led    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (load_done) begin
            period_reg     <= '0;
            bit_idx_reg    <= 3'd7;
            shift_reg      <= PREAMBLE;
            heater_bit_reg <= PREAMBLE[7];
          end else if (rx_ready) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
        end
        PRE, DATA: begin
          if (bit_wrap) begin
            period_reg <= '0;
            if (bit_idx_reg != 3'd0) begin
              bit_idx_reg    <= bit_idx_reg - 3'd1;
              heater_bit_reg <= shift_reg[6];
              shift_reg      <= {shift_reg[6:0], 1'b0};
            end else if ((state_reg == DATA) && (rd_ptr_reg == len_reg)) begin
              heater_bit_reg <= 1'b0;
            end else begin
              bit_idx_reg    <= 3'd7;
              shift_reg      <= rd_data_reg;
              heater_bit_reg <= rd_data_reg[7];
              rd_ptr_reg     <= rd_ptr_reg + AW'(1);
            end
          end else begin
            period_reg <= period_reg + PW'(1);
          end
        end
        GAP: begin
          if (bit_wrap) period_reg <= '0;
          else          period_reg <= period_reg + PW'(1);
        end
        ACK: begin
          if (!tx_busy) begin
            tx_data  <= ACK_BYTE;
            tx_start <= 1'b1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          end_led <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HEATERS; gi++) begin : g_heater
      assign heater_en[gi] = heater_bit_reg;
    end
  endgenerate

endmodule

// File: tb/tb_covert_tx_modulator.sv
// Directed bench for covert_tx_modulator: frames are pushed into a per-cycle heater
// scoreboard and an ack scoreboard, then popped and compared as the DUT runs.
module tb_covert_tx_modulator;

  localparam int BP = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [63:0] heater_en;
  logic        busy;
  logic        end_led;

  int checks = 0;
  int failures = 0;

  logic       exp_heat [$];
  logic [7:0] exp_ack  [$];
  logic [7:0] msg [16];

  covert_tx_modulator #(
    .BIT_PERIOD (BP),
    .NUM_HEATERS(64),
    .MSG_DEPTH  (16),
    .PREAMBLE   (8'hAA),
    .ACK_BYTE   (8'hA5)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .heater_en(heater_en),
    .busy     (busy),
    .end_led  (end_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--)
      repeat (BP) exp_heat.push_back(b[k]);
  endtask

  // Queue the expected heater trace (LOAD-completion cycle, preamble, payload, gap)
  // and the ack byte, then feed the frame over the rx strobe.
  task automatic send_frame(input int len);
    exp_heat.push_back(1'b0);
    push_byte(8'hAA);
    for (int k = 0; k < len; k++) push_byte(msg[k]);
    repeat (BP) exp_heat.push_back(1'b0);
    exp_ack.push_back(8'hA5);
    drive_byte(8'(len));
    check("load_busy", 64'(busy), 64'd1);
    check("load_end_led", 64'(end_led), 64'd0);
    for (int k = 0; k < len; k++) drive_byte(msg[k]);
  endtask

  task automatic run_heater(input bit noise, input int limit);
    logic e;
    int   i;
    i = 0;
    while (exp_heat.size() > 0 && i < limit) begin
      e = exp_heat.pop_front();
      check("heater", heater_en, {64{e}});
      if (noise && (i % 29 == 0)) begin
        rx_data  = 8'($urandom_range(0, 255));
        rx_ready = 1'b1;
      end else begin
        rx_ready = 1'b0;
      end
      i++;
      @(negedge clk);
    end
    rx_ready = 1'b0;
  endtask

  task automatic expect_ack(input int hold);
    logic [7:0] e;
    check("ack_wait_busy", 64'(busy), 64'd1);
    repeat (hold) begin
      check("ack_hold_start", 64'(tx_start), 64'd0);
      check("ack_hold_heater", heater_en, 64'd0);
      @(negedge clk);
    end
    check("ack_pre_start", 64'(tx_start), 64'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    e = exp_ack.pop_front();
    check("ack_start", 64'(tx_start), 64'd1);
    check("ack_data", 64'(tx_data), 64'(e));
    @(negedge clk);
    check("ack_pulse_end", 64'(tx_start), 64'd0);
    check("done_busy", 64'(busy), 64'd0);
    check("done_end_led", 64'(end_led), 64'd1);
  endtask

  initial begin
    rstn = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_heater", heater_en, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_end_led", 64'(end_led), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic one-byte frame
    msg[0] = 8'hC3;
    send_frame(1);
    run_heater(1'b0, 1 << 20);
    expect_ack(0);
    $display("frame L=1 payload=c3 done");

    // Invalid lengths are ignored
    drive_byte(8'h00);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_end_led", 64'(end_led), 64'd1);
    drive_byte(8'h11);
    check("len17_busy", 64'(busy), 64'd0);
    repeat (4) begin
      check("invalid_heater", heater_en, 64'd0);
      check("invalid_start", 64'(tx_start), 64'd0);
      @(negedge clk);
    end
    $display("invalid lengths 00 and 11 sent");

    // Same frame with stray rx strobes during LOAD completion / PRE / DATA
    send_frame(1);
    run_heater(1'b1, 1 << 20);
    expect_ack(0);
    $display("frame L=1 payload=c3 with stray rx done");

    // Full-depth frame
    for (int k = 0; k < 16; k++) msg[k] = 8'(k);
    send_frame(16);
    run_heater(1'b0, 1 << 20);
    expect_ack(0);
    $display("frame L=16 payload=00..0f done");

    // Ack held off by a busy UART transmitter
    msg[0] = 8'h5A; msg[1] = 8'h81;
    send_frame(2);
    tx_busy = 1'b1;
    run_heater(1'b0, 1 << 20);
    expect_ack(100);
    $display("frame L=2 with tx_busy hold done");

    // Asynchronous reset in the middle of an all-ones data byte
    msg[0] = 8'hFF;
    send_frame(1);
    run_heater(1'b0, 1 + 128 + 40);
    check("mid_data_heater", heater_en, {64{1'b1}});
    #2 rstn = 1'b0;
    #1;
    check("async_rst_heater", heater_en, 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_tx_data", 64'(tx_data), 64'd0);
    exp_heat.delete();
    exp_ack.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_heater", heater_en, 64'd0);
      check("post_rst_start", 64'(tx_start), 64'd0);
    end
    $display("reset mid-DATA applied");

    // Recovery frame after reset
    msg[0] = 8'h3C; msg[1] = 8'h01; msg[2] = 8'hE7;
    send_frame(3);
    run_heater(1'b0, 1 << 20);
    expect_ack(0);
    $display("frame L=3 after reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
